imm_encoder: RTL and testbench

- Inverse of the immediate decode path: packs opcode-class, register fields and a 32-bit signed immediate into a legal RV32I instruction word.
- Range- and alignment-checks the immediate against the instruction format.
- Emits each encoded word with a sequential instruction-memory address for test-program loading and the self-modifying-code bench.
- Sits between the bench/boot loader and instruction memory write port; valid/ready on both sides.

---
 rtl/imm_encoder_if.sv | 42 ++++
 rtl/imm_encoder.sv | 152 +++++++++++++++
 tb/tb_imm_encoder.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_encoder_if.sv
// imm_encoder_if: bundle of the input and output handshakes of imm_encoder.
//
// Handshake rules (both sides): a beat transfers on a rising clock edge
// where valid && ready are both high. A producer holding valid high keeps
// its payload stable until the beat transfers. ready may depend
// combinationally on the consumer's own state, but never on valid.
//
// Signals
//   in_valid/in_ready : field-input handshake (producer = master)
//   op_sel, funct3, rd, rs1, rs2, imm : instruction fields to encode
//   out_valid/out_ready : encoded-word handshake (producer = slave)
//   out_inst, out_addr, out_err : encoded word, its address, reject flag
// Modports
//   master : bench / boot loader side
//   slave  : encoder side
interface imm_encoder_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op_sel;
  logic [2:0]        funct3;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [31:0]       imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;

  modport master (
    output in_valid, op_sel, funct3, rd, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, out_inst, out_addr, out_err
  );

  modport slave (
    input  in_valid, op_sel, funct3, rd, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, out_inst, out_addr, out_err
  );
endinterface

// File: rtl/imm_encoder.sv
// imm_encoder: packs opcode class, register fields and a signed immediate
// into an RV32I instruction word (I/S/B/J formats), range/alignment checks
// the immediate and tags each word with a sequential instruction-memory
// address. One registered output stage, latency 1, full throughput.
//
// Ports
//   clk        : clock, all state on rising edge
//   reset      : asynchronous active-high reset
//   addr_clear : synchronous reload of address counter, clears err_count
//   bus        : imm_encoder_if.slave (field input + encoded output handshakes)
//   err_count  : saturating count of rejected inputs
//   chk_fail   : sticky internal re-decode mismatch flag
//
// Optional feature macro: IMM_ENCODER_SELFCHECK_EN
//   defined   : each legal word is re-decoded and its immediate compared with
//               the accepted one; a mismatch sets chk_fail until reset.
//   undefined : chk_fail is tied low.
module imm_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         addr_clear,
  imm_encoder_if.slave bus,
  output logic [7:0]   err_count,
  output logic         chk_fail
);

  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  logic              accept;
  logic              legal;
  logic [31:0]       enc;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] addr_base;
  logic [7:0]        err_base;
  logic              fit12;
  logic              fit13;
  logic              fit21;

  // An immediate fits an N-bit signed field when every bit above N-1
  // equals the sign bit, i.e. bits [31:N-1] are all zeros or all ones.
  assign fit12 = (bus.imm[31:11] == '0) || (bus.imm[31:11] == '1);
  assign fit13 = (bus.imm[31:12] == '0) || (bus.imm[31:12] == '1);
  assign fit21 = (bus.imm[31:20] == '0) || (bus.imm[31:20] == '1);

  always_comb begin
    enc   = '0;
    legal = 1'b0;
    case (bus.op_sel)
      3'd0: begin
        enc   = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, OPC_LOAD};
        legal = fit12;
      end
      3'd1: begin
        enc   = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], OPC_STORE};
        legal = fit12;
      end
      3'd2: begin
        enc   = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                 bus.imm[4:1], bus.imm[11], OPC_BRANCH};
        legal = fit13 && !bus.imm[0];
      end
      3'd3: begin
        enc   = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, OPC_OPIMM};
        legal = fit12;
      end
      3'd4: begin
        enc   = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, OPC_JAL};
        legal = fit21 && !bus.imm[0];
      end
      default: begin
        enc   = '0;
        legal = 1'b0;
      end
    endcase
  end

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // addr_clear takes effect before the accepted input picks its address,
  // so a same-cycle input is tagged with BASE_ADDR.
  assign addr_base = addr_clear ? BASE_ADDR : addr_cnt;
  assign err_base  = addr_clear ? 8'd0 : err_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_inst  <= '0;
      bus.out_addr  <= BASE_ADDR;
      bus.out_err   <= 1'b0;
      addr_cnt      <= BASE_ADDR;
      err_count     <= 8'd0;
    end else begin
      if (accept) begin
        bus.out_valid <= 1'b1;
        bus.out_inst  <= legal ? enc : NOP_INST;
        bus.out_addr  <= addr_base;
        bus.out_err   <= !legal;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      if (accept && legal) begin
        addr_cnt <= addr_base + ADDR_W'(4);
      end else begin
        addr_cnt <= addr_base;
      end

      if (accept && !legal && (err_base != 8'hFF)) begin
        err_count <= err_base + 8'd1;
      end else begin
        err_count <= err_base;
      end
    end
  end

`ifdef IMM_ENCODER_SELFCHECK_EN
  logic [31:0] dec_imm;

  // Pull the immediate back out of the freshly built word, exactly as a
  // decoder would, so a bit-placement slip shows up as a mismatch.
  always_comb begin
    dec_imm = '0;
    case (bus.op_sel)
      3'd0, 3'd3: dec_imm = {{20{enc[31]}}, enc[31:20]};
      3'd1:       dec_imm = {{20{enc[31]}}, enc[31:25], enc[11:7]};
      3'd2:       dec_imm = {{19{enc[31]}}, enc[31], enc[7], enc[30:25], enc[11:8], 1'b0};
      3'd4:       dec_imm = {{11{enc[31]}}, enc[31], enc[19:12], enc[20], enc[30:21], 1'b0};
      default:    dec_imm = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_fail <= 1'b0;
    end else if (accept && legal && (dec_imm != bus.imm)) begin
      chk_fail <= 1'b1;
    end
  end
`else
  assign chk_fail = 1'b0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed bench for imm_encoder. A transaction-level model
// (queue of pending output beats, counter, error count) predicts outputs
// from the instruction-format rules; a negedge process compares every cycle.
module tb_imm_encoder;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic       clk;
  logic       reset;
  logic       addr_clear;
  logic [7:0] err_count;
  logic       chk_fail;

  imm_encoder_if #(.ADDR_W(32)) bus ();

  imm_encoder #(.ADDR_W(32), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .addr_clear (addr_clear),
    .bus        (bus),
    .err_count  (err_count),
    .chk_fail   (chk_fail)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Returns {legal, word}; illegal inputs yield the NOP word.
  function automatic logic [32:0] model_enc(input logic [2:0] op, input logic [2:0] f3,
                                             input logic [4:0] rd_v, input logic [4:0] rs1_v,
                                             input logic [4:0] rs2_v, input logic [31:0] u);
    int s;
    logic [31:0] w;
    logic ok;
    s  = $signed(u);
    w  = 32'h13;
    ok = 1'b0;
    case (op)
      3'd0, 3'd3: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = ((u & 32'hFFF) << 20) | (32'(rs1_v) << 15) | (32'(f3) << 12) |
             (32'(rd_v) << 7) | ((op == 3'd0) ? 32'h03 : 32'h13);
      end
      3'd1: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = (((u >> 5) & 32'h7F) << 25) | (32'(rs2_v) << 20) | (32'(rs1_v) << 15) |
             (32'(f3) << 12) | ((u & 32'h1F) << 7) | 32'h23;
      end
      3'd2: begin
        ok = (s >= -4096) && (s <= 4094) && ((s & 1) == 0);
        w  = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) |
             (32'(rs2_v) << 20) | (32'(rs1_v) << 15) | (32'(f3) << 12) |
             (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7) | 32'h63;
      end
      3'd4: begin
        ok = (s >= -1048576) && (s <= 1048574) && ((s & 1) == 0);
        w  = (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21) |
             (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12) |
             (32'(rd_v) << 7) | 32'h6F;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) w = 32'h13;
    return {ok, w};
  endfunction

  logic [64:0] exp_q[$];   // {err, addr, inst} of the beat waiting downstream
  logic [31:0] m_cnt;
  logic [7:0]  m_errc;
  logic [31:0] m_base;
  logic [7:0]  m_ebase;
  logic [32:0] m_r;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      m_cnt  <= BASE;
      m_errc <= 8'd0;
    end else begin
      m_base  = addr_clear ? BASE : m_cnt;
      m_ebase = addr_clear ? 8'd0 : m_errc;
      if (bus.in_valid && (exp_q.size() == 0 || bus.out_ready)) begin
        m_r = model_enc(bus.op_sel, bus.funct3, bus.rd, bus.rs1, bus.rs2, bus.imm);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        exp_q.push_back({~m_r[32], m_base, m_r[31:0]});
        if (m_r[32]) begin
          m_cnt  <= m_base + 32'd4;
          m_errc <= m_ebase;
        end else begin
          m_cnt  <= m_base;
          m_errc <= (m_ebase == 8'hFF) ? 8'hFF : m_ebase + 8'd1;
        end
      end else begin
        if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
        m_cnt  <= m_base;
        m_errc <= m_ebase;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!reset) begin
      chk("in_ready", bus.in_ready, (exp_q.size() == 0) || bus.out_ready);
      chk("out_valid", bus.out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("out_inst", bus.out_inst, exp_q[0][31:0]);
        chk("out_addr", bus.out_addr, exp_q[0][63:32]);
        chk("out_err", bus.out_err, exp_q[0][64]);
      end
      chk("err_count", err_count, m_errc);
      chk("chk_fail", chk_fail, 1'b0);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at negedge+1; returns at negedge+1 of the cycle after acceptance.
  task automatic send(input logic [2:0] op, input logic [2:0] f3, input logic [4:0] rd_v,
                      input logic [4:0] rs1_v, input logic [4:0] rs2_v, input int imm_v);
    int n;
    n = 0;
    bus.op_sel   = op;
    bus.funct3   = f3;
    bus.rd       = rd_v;
    bus.rs1      = rs1_v;
    bus.rs2      = rs2_v;
    bus.imm      = imm_v;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      chk("send_timeout", 1'b0, 1'b1);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b0;
    addr_clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.op_sel = '0;
    bus.funct3 = '0;
    bus.rd = '0;
    bus.rs1 = '0;
    bus.rs2 = '0;
    bus.imm = '0;
    #1 reset = 1'b1;
    idle(2);
    reset = 1'b0;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_inst", bus.out_inst, 32'h0);
    chk("rst_out_addr", bus.out_addr, BASE);
    chk("rst_err_count", err_count, 8'h00);
    chk("rst_in_ready", bus.in_ready, 1'b1);

    // Main formats, back-to-back.
    send(3'd0, 3'd2, 5'd5, 5'd2, 5'd0, -4);
    chk("load_inst", bus.out_inst, 32'hFFC12283);
    chk("load_addr", bus.out_addr, BASE);
    chk("load_err", bus.out_err, 1'b0);
    send(3'd1, 3'd2, 5'd0, 5'd2, 5'd6, 8);
    chk("store_inst", bus.out_inst, 32'h00612423);
    send(3'd2, 3'd0, 5'd0, 5'd1, 5'd2, -8);
    chk("branch_inst", bus.out_inst, 32'hFE208CE3);
    chk("branch_addr", bus.out_addr, BASE + 32'd8);
    send(3'd4, 3'd0, 5'd1, 5'd0, 5'd0, 2048);
    chk("jal_inst", bus.out_inst, 32'h001000EF);

    // Illegal inputs.
    send(3'd2, 3'd0, 5'd0, 5'd1, 5'd2, 3);
    send(3'd3, 3'd0, 5'd1, 5'd1, 5'd0, 2048);
    send(3'd6, 3'd0, 5'd1, 5'd1, 5'd0, 0);
    chk("ill_inst", bus.out_inst, 32'h00000013);
    chk("ill_err", bus.out_err, 1'b1);
    chk("ill_addr", bus.out_addr, BASE + 32'd16);
    chk("ill_count3", err_count, 8'd3);
    for (int i = 0; i < 300; i++) begin
      case (i % 4)
        0: send(3'(5 + (i % 3)), 3'd0, 5'd1, 5'd1, 5'd1, i);
        1: send(3'd0, 3'd1, 5'd1, 5'd1, 5'd0, 2048 + i);
        2: send(3'd2, 3'd1, 5'd0, 5'd1, 5'd2, 2 * i + 1);
        default: send(3'd4, 3'd0, 5'd1, 5'd0, 5'd0, 1048576 + 2 * i);
      endcase
    end
    chk("err_sat", err_count, 8'hFF);

    // Boundary immediates.
    send(3'd3, 3'd0, 5'd1, 5'd0, 5'd0, 2047);
    chk("i_max_inst", bus.out_inst, 32'h7FF00093);
    send(3'd0, 3'd0, 5'd1, 5'd0, 5'd0, -2048);
    send(3'd2, 3'd0, 5'd0, 5'd0, 5'd0, -4096);
    chk("b_min_inst", bus.out_inst, 32'h80000063);
    send(3'd2, 3'd0, 5'd0, 5'd0, 5'd0, 4096);
    send(3'd4, 3'd0, 5'd1, 5'd0, 5'd0, 1048574);
    send(3'd4, 3'd0, 5'd1, 5'd0, 5'd0, -1048576);
    send(3'd4, 3'd0, 5'd1, 5'd0, 5'd0, 1048576);
    chk("j_over_err", bus.out_err, 1'b1);
    send(3'd1, 3'd7, 5'd0, 5'd31, 5'd31, -2049);

    // Back-pressure stall.
    idle(2);
    bus.out_ready = 1'b0;
    send(3'd3, 3'd0, 5'd3, 5'd4, 5'd0, 100);
    chk("stall_a_inst", bus.out_inst, 32'h06420193);
    bus.op_sel = 3'd3; bus.funct3 = 3'd0; bus.rd = 5'd1; bus.rs1 = 5'd0; bus.imm = -1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("stall_in_ready", bus.in_ready, 1'b0);
      chk("stall_frozen", bus.out_inst, 32'h06420193);
    end
    bus.out_ready = 1'b1;
    idle(1);
    bus.in_valid = 1'b0;
    chk("drain_fill_inst", bus.out_inst, 32'hFFF00093);
    bus.out_ready = 1'b0;
    idle(2);

    // Asynchronous reset in the middle of the stall.
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_valid", bus.out_valid, 1'b0);
    chk("mid_rst_inst", bus.out_inst, 32'h0);
    chk("mid_rst_addr", bus.out_addr, BASE);
    chk("mid_rst_errc", err_count, 8'h00);
    chk("mid_rst_chk", chk_fail, 1'b0);
    idle(1);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    send(3'd4, 3'd0, 5'd0, 5'd0, 5'd0, -4);
    chk("post_rst_inst", bus.out_inst, 32'hFFDFF06F);
    chk("post_rst_addr", bus.out_addr, BASE);

    // addr_clear with same-cycle inputs.
    send(3'd0, 3'd2, 5'd7, 5'd8, 5'd0, 12);
    send(3'd7, 3'd0, 5'd0, 5'd0, 5'd0, 0);
    addr_clear = 1'b1;
    send(3'd2, 3'd1, 5'd0, 5'd3, 5'd4, 4094);
    addr_clear = 1'b0;
    chk("clr_legal_addr", bus.out_addr, BASE);
    chk("clr_legal_errc", err_count, 8'd0);
    send(3'd3, 3'd0, 5'd2, 5'd2, 5'd0, 1);
    chk("clr_next_addr", bus.out_addr, BASE + 32'd4);
    addr_clear = 1'b1;
    send(3'd4, 3'd0, 5'd1, 5'd0, 5'd0, 5);
    addr_clear = 1'b0;
    chk("clr_ill_addr", bus.out_addr, BASE);
    chk("clr_ill_errc", err_count, 8'd1);
    send(3'd3, 3'd0, 5'd2, 5'd2, 5'd0, 1);
    chk("clr_ill_next", bus.out_addr, BASE);
    addr_clear = 1'b1;
    idle(1);
    addr_clear = 1'b0;
    chk("clr_pending_kept", bus.out_valid, 1'b0);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
